ps2_scancode_decoder: RTL

Consumes the byte stream produced by the PS/2 receiver (one byte plus a single-cycle valid strobe per frame) and parses set-2 scancode sequences into key events. Decoding covers the 0xE0 extended prefix, 0xF0 break prefix and typematic repeats. Decoded events are buffered in a small FIFO and presented on a valid/ready port to downstream display/console logic. The block also keeps a running count of distinct key presses.

---
 rtl/ps2_scancode_decoder.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/ps2_scancode_decoder.sv
// ps2_scancode_decoder
//   Parses the PS/2 set-2 byte stream (0xE0 extended prefix, 0xF0 break
//   prefix, typematic repeats) into key events. Events are queued in a
//   show-ahead FIFO and offered on a valid/ready port. A running count of
//   distinct (non-repeat) key presses is kept.
//
//   Optional feature macro: PS2_ASCII_EN -- when defined, a combinational
//   set-2 to ASCII table fills the stored ascii field; when undefined the
//   field is not stored and ev_ascii is tied to 0x00.
//
// Ports
//   clk        in   system clock (same domain as the PS/2 receiver)
//   reset      in   synchronous, active-high reset
//   rx_data    in   [7:0] received scancode byte
//   rx_valid   in   one-cycle strobe qualifying rx_data
//   ev_valid   out  FIFO head holds an event
//   ev_ready   in   consumer accepts the head event
//   ev_code    out  [7:0] scancode with prefixes stripped
//   ev_ext     out  event was 0xE0-prefixed
//   ev_break   out  1 = release, 0 = press
//   ev_repeat  out  make event matching the currently held key
//   ev_ascii   out  [7:0] ASCII of the key, 0x00 if none
//   key_count  out  [7:0] count of non-repeat make events, wraps
//   drop       out  sticky: an event was lost because the FIFO was full
module ps2_scancode_decoder #(
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       ev_valid,
  input  logic       ev_ready,
  output logic [7:0] ev_code,
  output logic       ev_ext,
  output logic       ev_break,
  output logic       ev_repeat,
  output logic [7:0] ev_ascii,
  output logic [7:0] key_count,
  output logic       drop
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
`ifdef PS2_ASCII_EN
  localparam int unsigned EW = 19;  // {code, ext, break, repeat, ascii}
`else
  localparam int unsigned EW = 11;  // {code, ext, break, repeat}
`endif

  typedef enum logic [1:0] {S_IDLE, S_EXT, S_BRK, S_EXT_BRK} state_t;

  state_t          state_q, state_d;
  logic            emit, new_ext, new_brk, new_rep, key_match, is_ignored;
  logic [7:0]      key_count_q, key_count_d;
  logic            held_valid_q, held_valid_d;
  logic [8:0]      held_q, held_d;
  logic            drop_q, drop_d;
  logic [AW:0]     wptr_q, wptr_d, rptr_q, rptr_d;
  logic            empty, full, push, pop;
  logic [EW-1:0]   mem_q [FIFO_DEPTH];
  logic [EW-1:0]   entry_n, head;

`ifdef PS2_ASCII_EN
  function automatic logic [7:0] set2_ascii(input logic [7:0] c);
    case (c)
      8'h1C: return 8'h61;  8'h32: return 8'h62;  8'h21: return 8'h63;
      8'h23: return 8'h64;  8'h24: return 8'h65;  8'h2B: return 8'h66;
      8'h34: return 8'h67;  8'h33: return 8'h68;  8'h43: return 8'h69;
      8'h3B: return 8'h6A;  8'h42: return 8'h6B;  8'h4B: return 8'h6C;
      8'h3A: return 8'h6D;  8'h31: return 8'h6E;  8'h44: return 8'h6F;
      8'h4D: return 8'h70;  8'h15: return 8'h71;  8'h2D: return 8'h72;
      8'h1B: return 8'h73;  8'h2C: return 8'h74;  8'h3C: return 8'h75;
      8'h2A: return 8'h76;  8'h1D: return 8'h77;  8'h22: return 8'h78;
      8'h35: return 8'h79;  8'h1A: return 8'h7A;
      8'h45: return 8'h30;  8'h16: return 8'h31;  8'h1E: return 8'h32;
      8'h26: return 8'h33;  8'h25: return 8'h34;  8'h2E: return 8'h35;
      8'h36: return 8'h36;  8'h3D: return 8'h37;  8'h3E: return 8'h38;
      8'h46: return 8'h39;
      8'h29: return 8'h20;  8'h5A: return 8'h0D;  8'h66: return 8'h08;
      default: return 8'h00;
    endcase
  endfunction
`endif

  // Keyboard status/ack bytes that carry no key information outside a sequence.
  always_comb begin
    case (rx_data)
      8'h00, 8'hAA, 8'hE1, 8'hEE, 8'hFA, 8'hFE, 8'hFF: is_ignored = 1'b1;
      default:                                         is_ignored = 1'b0;
    endcase
  end

  // Parser next-state and event emission
  always_comb begin
    state_d = state_q;
    emit    = 1'b0;
    new_ext = 1'b0;
    new_brk = 1'b0;
    if (rx_valid) begin
      case (state_q)
        S_IDLE: begin
          if (rx_data == 8'hE0)      state_d = S_EXT;
          else if (rx_data == 8'hF0) state_d = S_BRK;
          else if (!is_ignored)      emit    = 1'b1;
        end
        S_EXT: begin
          if (rx_data == 8'hF0) state_d = S_EXT_BRK;
          else if (rx_data != 8'hE0) begin
            emit    = 1'b1;
            new_ext = 1'b1;
            state_d = S_IDLE;
          end
        end
        S_BRK: begin
          if (rx_data != 8'hE0 && rx_data != 8'hF0) begin
            emit    = 1'b1;
            new_brk = 1'b1;
            state_d = S_IDLE;
          end
        end
        S_EXT_BRK: begin
          if (rx_data != 8'hE0 && rx_data != 8'hF0) begin
            emit    = 1'b1;
            new_ext = 1'b1;
            new_brk = 1'b1;
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Held-key tracker and press counter; updated for every emitted event,
  // independent of whether the FIFO has room.
  assign key_match = held_valid_q && (held_q == {new_ext, rx_data});

  always_comb begin
    key_count_d  = key_count_q;
    held_valid_d = held_valid_q;
    held_d       = held_q;
    new_rep      = 1'b0;
    if (emit) begin
      if (!new_brk) begin
        if (key_match) begin
          new_rep = 1'b1;
        end else begin
          key_count_d  = key_count_q + 8'd1;
          held_d       = {new_ext, rx_data};
          held_valid_d = 1'b1;
        end
      end else if (key_match) begin
        held_valid_d = 1'b0;
      end
    end
  end

  // FIFO control: a pop frees the slot in the same cycle, so a full FIFO
  // still accepts a push when the head is being consumed.
  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign pop   = !empty && ev_ready;
  assign push  = emit && (!full || pop);

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    drop_d = drop_q;
    if (push) wptr_d = wptr_q + (AW+1)'(1);
    if (pop)  rptr_d = rptr_q + (AW+1)'(1);
    if (emit && full && !pop) drop_d = 1'b1;
  end

`ifdef PS2_ASCII_EN
  assign entry_n = {rx_data, new_ext, new_brk, new_rep,
                    (new_ext ? 8'h00 : set2_ascii(rx_data))};
`else
  assign entry_n = {rx_data, new_ext, new_brk, new_rep};
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      key_count_q  <= '0;
      held_valid_q <= 1'b0;
      held_q       <= '0;
      drop_q       <= 1'b0;
      wptr_q       <= '0;
      rptr_q       <= '0;
    end else begin
      state_q      <= state_d;
      key_count_q  <= key_count_d;
      held_valid_q <= held_valid_d;
      held_q       <= held_d;
      drop_q       <= drop_d;
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
    end
  end

  // Storage needs no reset; occupancy is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (push && !reset) mem_q[wptr_q[AW-1:0]] <= entry_n;
  end

  assign head      = mem_q[rptr_q[AW-1:0]];
  assign ev_valid  = !empty;
  assign ev_code   = head[EW-1 -: 8];
  assign ev_ext    = head[EW-9];
  assign ev_break  = head[EW-10];
  assign ev_repeat = head[EW-11];
`ifdef PS2_ASCII_EN
  assign ev_ascii  = head[7:0];
`else
  assign ev_ascii  = '0;
`endif
  assign key_count = key_count_q;
  assign drop      = drop_q;

endmodule
